// File: rtl/ecc_isa_pkg.sv
// ISA constants, FSM state encoding and decoded-control bundle shared by the
// ECC issue/control sequencer and its instruction decoder.
package ecc_isa_pkg;

    // Instruction field bit positions (20-bit instruction word)
    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 15;
    localparam int RD_MSB  = 14;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 5;
    localparam int RT_MSB  = 4;
    localparam int RT_LSB  = 0;

    // Control-flow opcodes
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_BRZ  = 5'b00001;
    localparam logic [4:0] OP_BRZP = 5'b00010;
    localparam logic [4:0] OP_BRNP = 5'b00011;
    localparam logic [4:0] OP_BRNZ = 5'b00100;
    localparam logic [4:0] OP_JSR  = 5'b01000;
    localparam logic [4:0] OP_RTI  = 5'b01010;

    // Write-back opcodes occupy the remaining defined encodings
    localparam logic [4:0] OP_ADD  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_CONST= 5'b01011;
    localparam logic [4:0] OP_SLL  = 5'b01100;
    localparam logic [4:0] OP_SRL  = 5'b01101;
    localparam logic [4:0] OP_SDRH = 5'b01110;
    localparam logic [4:0] OP_SDRL = 5'b01111;
    localparam logic [4:0] OP_SDL  = 5'b10000;
    localparam logic [4:0] OP_CHKL = 5'b10010;
    localparam logic [4:0] OP_CHKH = 5'b10011;
    localparam logic [4:0] OP_TCS  = 5'b10100;
    localparam logic [4:0] OP_TCDH = 5'b10101;

    // Condition codes {N,Z,P} after reset: "zero"
    localparam logic [2:0] NZP_RESET = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // Decoded control for the instruction in EXEC. br_mask selects which of
    // {N,Z,P} make a branch taken; all-zero means "not a branch".
    typedef struct packed {
        logic       rf_we;
        logic       carry_we;
        logic       nzp_we;
        logic [2:0] br_mask;
        logic       is_jump;
        logic       illegal;
    } dec_t;

    // A conditional branch is taken when any selected condition code is set
    function automatic logic branch_taken(input logic [2:0] mask, input logic [2:0] nzp);
        return |(mask & nzp);
    endfunction

endpackage

// File: rtl/ecc_issue_ctrl_if.sv
// Bundle of control, instruction-memory, ALU and register-file signals between
// the issue sequencer (master) and the datapath/memory side (slave).
interface ecc_issue_ctrl_if #(
    parameter int WORD_SIZE = 256,
    parameter int INSN      = 19,
    parameter int IADDR     = 10,
    parameter int DADDR     = 4
);
    logic                 start;
    logic                 stop;
    logic                 imem_req;
    logic [IADDR:0]       imem_addr;
    logic                 imem_valid;
    logic [INSN:0]        imem_data;
    logic [INSN:0]        alu_insn;
    logic [IADDR:0]       alu_pc;
    logic                 alu_carry;
    logic                 alu_carry_out;
    logic [WORD_SIZE-1:0] alu_result;
    logic [DADDR:0]       rf_rs_addr;
    logic [DADDR:0]       rf_rt_addr;
    logic [DADDR:0]       rf_wr_addr;
    logic                 rf_we;
    logic                 busy;
    logic                 retired;
    logic                 illegal;
    logic [2:0]           nzp;

    modport master (
        input  start, stop, imem_valid, imem_data, alu_carry_out, alu_result,
        output imem_req, imem_addr, alu_insn, alu_pc, alu_carry,
               rf_rs_addr, rf_rt_addr, rf_wr_addr, rf_we,
               busy, retired, illegal, nzp
    );

    modport slave (
        output start, stop, imem_valid, imem_data, alu_carry_out, alu_result,
        input  imem_req, imem_addr, alu_insn, alu_pc, alu_carry,
               rf_rs_addr, rf_rt_addr, rf_wr_addr, rf_we,
               busy, retired, illegal, nzp
    );
endinterface

// File: rtl/ecc_insn_decode.sv
// Combinational opcode decoder: classifies an instruction into write-back,
// flag-update, branch/jump and illegal controls.
module ecc_insn_decode
    import ecc_isa_pkg::*;
(
    input  logic [4:0] opcode,
    output dec_t       dec
);

    // Opcode classification; undefined encodings decode as NOP plus illegal
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        dec = '0;
        unique case (opcode)
            OP_NOP:  ;
            OP_BRZ:  dec.br_mask = 3'b010;
            OP_BRZP: dec.br_mask = 3'b011;
            OP_BRNP: dec.br_mask = 3'b101;
            OP_BRNZ: dec.br_mask = 3'b110;
            OP_JSR,
            OP_RTI:  dec.is_jump = 1'b1;
            OP_ADD, OP_SUB, OP_ADDI, OP_TCS, OP_TCDH: begin
                dec.rf_we    = 1'b1;
                dec.nzp_we   = 1'b1;
                dec.carry_we = 1'b1;
            end
            OP_AND, OP_CONST, OP_SLL, OP_SRL, OP_SDRH,
            OP_SDRL, OP_SDL, OP_CHKL, OP_CHKH: begin
                dec.rf_we  = 1'b1;
                dec.nzp_we = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ecc_issue_ctrl.sv
// Issue/control sequencer for the 256-bit ECC datapath: fetches instructions,
// presents them to the combinational ALU and retires them by updating PC,
// carry flag and NZP condition codes.
module ecc_issue_ctrl
    import ecc_isa_pkg::*;
#(
    parameter int WORD_SIZE = 256,
    parameter int INSN      = 19,
    parameter int IADDR     = 10,
    parameter int DADDR     = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ecc_issue_ctrl_if.master      bus
);

    localparam logic [IADDR:0] PC_RESET = IADDR'(RESET_PC);
    localparam logic [IADDR:0] PC_ONE   = 1;

    state_t         state_q, state_d;
    logic           stop_seen_q, stop_seen_d;
    logic [IADDR:0] pc_q, pc_d;
    logic [INSN:0]  insn_q;
    logic           carry_q;
    logic [2:0]     nzp_q;

    dec_t           dec;
    logic           in_exec;
    logic           insn_load;
    logic           res_n, res_z;
    logic [DADDR:0] rs_addr, rt_addr, rd_addr;

    ecc_insn_decode u_decode (
        .opcode (insn_q[OPC_MSB:OPC_LSB]),
        .dec    (dec)
    );

    assign in_exec   = (state_q == EXEC);
    assign insn_load = (state_q == FETCH) && bus.imem_valid;
    assign res_n     = bus.alu_result[WORD_SIZE-1];
    assign res_z     = (bus.alu_result == '0);

    // Next state; stop is remembered from the start of FETCH so the current
    // instruction always retires before returning to IDLE
    always_comb begin
        state_d     = state_q;
        stop_seen_d = stop_seen_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d     = FETCH;
                    stop_seen_d = 1'b0;
                end
            end
            FETCH: begin
                stop_seen_d = stop_seen_q | bus.stop;
                if (bus.imem_valid) state_d = EXEC;
            end
            EXEC: begin
                if (stop_seen_q || bus.stop) begin
                    state_d = IDLE;
                end else begin
                    state_d     = FETCH;
                    stop_seen_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; async reset also kills an outstanding fetch request
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q     <= IDLE;
            stop_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    // Next PC: jumps and taken branches load the ALU-computed target, all
    // others advance by one; both wrap naturally at the PC width
    always_comb begin
        pc_d = pc_q;
        if (in_exec) begin
            if (dec.is_jump || branch_taken(dec.br_mask, nzp_q))
                pc_d = bus.alu_result[IADDR:0];
            else
                pc_d = pc_q + PC_ONE;
        end
    end

    // Architectural state: PC, instruction register, carry and NZP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_RESET;
            insn_q  <= '0;
            carry_q <= 1'b0;
            nzp_q   <= NZP_RESET;
        end else begin
            pc_q <= pc_d;
            if (insn_load)
                insn_q <= bus.imem_data;
            if (in_exec && dec.carry_we)
                carry_q <= bus.alu_carry_out;
            if (in_exec && dec.nzp_we)
                nzp_q <= {res_n, res_z, !res_n && !res_z};
        end
    end

    assign rs_addr = insn_q[RS_MSB:RS_LSB];
    assign rt_addr = insn_q[RT_MSB:RT_LSB];
    assign rd_addr = insn_q[RD_MSB:RD_LSB];

    assign bus.imem_req   = (state_q == FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.alu_insn   = insn_q;
    assign bus.alu_pc     = pc_q;
    assign bus.alu_carry  = carry_q;
    assign bus.rf_rs_addr = rs_addr;
    assign bus.rf_rt_addr = rt_addr;
    assign bus.rf_wr_addr = rd_addr;
    assign bus.rf_we      = in_exec && dec.rf_we;
    assign bus.busy       = (state_q != IDLE);
    assign bus.retired    = in_exec;
    assign bus.illegal    = in_exec && dec.illegal;
    assign bus.nzp        = nzp_q;

endmodule
